// File: rtl/tmp75_multi_poller.sv
// Round-robin poller for up to N_CH TMP75-family sensors behind one byte-stream I2C master.
// Latency: per channel ~6 control cycles + max(conv_wait,1) + GAP_CYC, plus master bus time.
// Backpressure: tx holds valid/data until tx_ready; rx waits on rx_valid; any wait aborts at TIMEOUT_CYC.
//
// Ports:
//   clk, rst_n            clock, async active-low reset (sync release expected from the top level)
//   enable                run polling; on deassert the current channel completes, then IDLE
//   ch_addr               per-channel A2..A0, channel k at [k*ADDR_W +: ADDR_W]
//   conv_wait             conversion wait, sampled when the pointer byte completes
//   alert_thr             signed over-temperature threshold, sampled at commit
//   take_bus/tx_*/rx_*    byte-stream handshake to i2c_master_ctrl; ack_lost = NACK/arb loss
//   temp_bus/temp_valid/temp_err/alert   per-channel result registers
//   sample_stb/sample_ch  one-cycle update pulse and its channel; busy = not IDLE
module tmp75_multi_poller #(
    parameter int N_CH        = 4,
    parameter int ADDR_W      = 3,
    parameter int CNT_W       = 32,
    parameter int GAP_CYC     = 640,
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [N_CH*ADDR_W-1:0] ch_addr,
    input  logic [CNT_W-1:0]       conv_wait,
    input  logic [15:0]            alert_thr,
    output logic                   take_bus,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   ack_lost,
    output logic [N_CH*16-1:0]     temp_bus,
    output logic [N_CH-1:0]        temp_valid,
    output logic [N_CH-1:0]        temp_err,
    output logic [N_CH-1:0]        alert,
    output logic                   sample_stb,
    output logic [2:0]             sample_ch,
    output logic                   busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_PTR_TAKE, S_PTR_ADDR, S_PTR_BYTE, S_CONV, S_RD_TAKE, S_RD_ADDR,
        S_RD_MSB, S_RD_LSB, S_COMMIT, S_COMMIT_ERR, S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    // COMMIT is the first cycle of the inter-channel gap, so GAP itself lasts GAP_CYC-1.
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC >= 2) ? GAP_CYC - 2 : 0);
    localparam logic [2:0]       CH_LAST  = 3'(N_CH - 1);

    state_t                r_state, w_next;
    logic [2:0]            r_ch;
    logic [ADDR_W-1:0]     r_addr;
    logic [7:0]            r_msb;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_conv_lim;
    logic                  r_take_bus, r_tx_vld, r_rx_rdy, r_stb, r_busy;
    logic [2:0]            r_sample_ch;
    logic [N_CH*16-1:0]    r_temp;
    logic [N_CH-1:0]       r_valid, r_err, r_alert;

    logic [ADDR_W-1:0]     w_cur_addr;
    logic                  w_tx_xfer, w_rx_xfer, w_hs, w_timeout, w_abort, w_conv_done;
    logic [15:0]           w_sample;
    logic                  w_sample_alert;

    always_comb begin
        w_cur_addr = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (r_ch == 3'(k)) w_cur_addr = ch_addr[k*ADDR_W +: ADDR_W];
        end
    end

    assign w_tx_xfer      = r_tx_vld & tx_ready;
    assign w_rx_xfer      = rx_valid & r_rx_rdy;
    // States that hold the bus and wait on the master; these are timeout-guarded.
    assign w_hs           = r_state inside {S_PTR_TAKE, S_PTR_ADDR, S_PTR_BYTE, S_RD_TAKE,
                                            S_RD_ADDR, S_RD_MSB, S_RD_LSB};
    assign w_timeout      = w_hs && (r_cnt == TO_LAST);
    assign w_abort        = ((w_hs || (r_state == S_CONV)) && ack_lost) || w_timeout;
    // conv_wait of 0 or 1 both give a single CONV cycle.
    assign w_conv_done    = (r_cnt + CNT_W'(1)) >= r_conv_lim;
    // LSB is taken straight off rx_data so the result is visible in the COMMIT cycle.
    assign w_sample       = {r_msb, rx_data};
    assign w_sample_alert = $signed(w_sample) >= $signed(alert_thr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (enable) w_next = S_PTR_TAKE;
            S_PTR_TAKE:   w_next = S_PTR_ADDR;
            S_PTR_ADDR:   if (w_tx_xfer) w_next = S_PTR_BYTE;
            S_PTR_BYTE:   if (w_tx_xfer) w_next = S_CONV;
            S_CONV:       if (w_conv_done) w_next = S_RD_TAKE;
            S_RD_TAKE:    w_next = S_RD_ADDR;
            S_RD_ADDR:    if (w_tx_xfer) w_next = S_RD_MSB;
            S_RD_MSB:     if (w_rx_xfer) w_next = S_RD_LSB;
            S_RD_LSB:     if (w_rx_xfer) w_next = S_COMMIT;
            S_COMMIT:     w_next = S_GAP;
            S_COMMIT_ERR: w_next = S_GAP;
            S_GAP:        if (r_cnt == GAP_LAST) w_next = enable ? S_PTR_TAKE : S_IDLE;
            default:      w_next = S_IDLE;
        endcase
        if (w_abort) w_next = S_COMMIT_ERR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch        <= '0;
            r_addr      <= '0;
            r_msb       <= '0;
            r_cnt       <= '0;
            r_conv_lim  <= '0;
            r_take_bus  <= 1'b0;
            r_tx_vld    <= 1'b0;
            r_rx_rdy    <= 1'b0;
            r_stb       <= 1'b0;
            r_busy      <= 1'b0;
            r_sample_ch <= '0;
            r_temp      <= '0;
            r_valid     <= '0;
            r_err       <= '0;
            r_alert     <= '0;
        end else begin
            // One counter serves the handshake timeout and the CONV/GAP delays.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (w_hs || (r_state == S_CONV) || (r_state == S_GAP))
                r_cnt <= r_cnt + CNT_W'(1);
            else
                r_cnt <= '0;

            // Handshake outputs are decoded from the next state so they are glitch-free
            // and drop in the cycle after a transfer or abort.
            r_take_bus <= w_next inside {S_PTR_TAKE, S_PTR_ADDR, S_PTR_BYTE, S_RD_TAKE,
                                         S_RD_ADDR, S_RD_MSB, S_RD_LSB};
            // Forced low for one cycle after each transfer, even between back-to-back bytes.
            r_tx_vld   <= (w_next inside {S_PTR_ADDR, S_PTR_BYTE, S_RD_ADDR}) && !w_tx_xfer;
            r_rx_rdy   <= w_next inside {S_RD_MSB, S_RD_LSB};
            r_stb      <= w_next inside {S_COMMIT, S_COMMIT_ERR};
            r_busy     <= w_next != S_IDLE;

            // Address is frozen per transaction so a live ch_addr change waits for the next one.
            if (r_state == S_PTR_TAKE) r_addr <= w_cur_addr;
            if ((r_state == S_PTR_BYTE) && w_tx_xfer) r_conv_lim <= conv_wait;
            if ((r_state == S_RD_MSB) && w_rx_xfer) r_msb <= rx_data;

            if ((w_next == S_COMMIT) && (r_state != S_COMMIT)) begin
                r_sample_ch <= r_ch;
                for (int k = 0; k < N_CH; k++) begin
                    if (r_ch == 3'(k)) begin
                        r_temp[k*16 +: 16] <= w_sample;
                        r_valid[k]         <= 1'b1;
                        r_err[k]           <= 1'b0;
                        r_alert[k]         <= w_sample_alert;
                    end
                end
            end

            if ((w_next == S_COMMIT_ERR) && (r_state != S_COMMIT_ERR)) begin
                r_sample_ch <= r_ch;
                for (int k = 0; k < N_CH; k++) begin
                    if (r_ch == 3'(k)) r_err[k] <= 1'b1;
                end
            end

            if ((r_state == S_GAP) && (w_next != S_GAP))
                r_ch <= (r_ch == CH_LAST) ? 3'd0 : r_ch + 3'd1;
        end
    end

    always_comb begin
        tx_data = 8'h00;
        case (r_state)
            S_PTR_ADDR: tx_data = {4'b1001, r_addr, 1'b0};
            S_RD_ADDR:  tx_data = {4'b1001, r_addr, 1'b1};
            default:    tx_data = 8'h00;
        endcase
    end

    assign take_bus   = r_take_bus;
    assign tx_valid   = r_tx_vld;
    assign rx_ready   = r_rx_rdy;
    assign temp_bus   = r_temp;
    assign temp_valid = r_valid;
    assign temp_err   = r_err;
    assign alert      = r_alert;
    assign sample_stb = r_stb;
    assign sample_ch  = r_sample_ch;
    assign busy       = r_busy;

endmodule

// File: tb/tb_tmp75_multi_poller.sv
// Bench for tmp75_multi_poller: two channels, random master/sensor timing and readings.
// Latency: each transaction is awaited on sample_stb with a bounded cycle budget.
// Backpressure: the master model stalls tx_ready/rx_valid at random, or holds tx_ready low.
module tb_tmp75_multi_poller;
    localparam int N_CH = 2, ADDR_W = 3, CNT_W = 32, GAP_CYC = 640, TIMEOUT_CYC = 100;

    logic                   clk = 1'b0;
    logic                   rst_n, enable, ack_lost;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [CNT_W-1:0]       conv_wait;
    logic [15:0]            alert_thr;
    logic                   take_bus, tx_valid, rx_ready, sample_stb, busy;
    logic                   tx_ready = 1'b0, rx_valid = 1'b0;
    logic [7:0]             tx_data;
    logic [7:0]             rx_data = 8'h00;
    logic [N_CH*16-1:0]     temp_bus;
    logic [N_CH-1:0]        temp_valid, temp_err, alert;
    logic [2:0]             sample_ch;

    tmp75_multi_poller #(.N_CH(N_CH), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .GAP_CYC(GAP_CYC),
                         .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_addr(ch_addr), .conv_wait(conv_wait),
        .alert_thr(alert_thr), .take_bus(take_bus), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ack_lost(ack_lost), .temp_bus(temp_bus), .temp_valid(temp_valid), .temp_err(temp_err),
        .alert(alert), .sample_stb(sample_stb), .sample_ch(sample_ch), .busy(busy));

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Sensor contents by I2C address, and the bytes the master has accepted.
    logic [15:0] sens [8];
    logic [7:0]  txlog [$];
    bit          no_ready = 1'b0;

    // Reference state: what the result registers should hold.
    logic [15:0] m_temp [N_CH];
    logic [N_CH-1:0] m_valid = '0, m_err = '0, m_alert = '0;
    logic [2:0]  m_addr [N_CH];
    int          m_ch = 0;

    // Timing observations, all in negedge-sampled cycle numbers.
    int cyc = 0, t_ptr = 0, t_stb = 0, t_txv_rise = 0;
    int conv_meas = -1, gap_meas = -1, txv_len = -1;
    bit ptr_pend = 1'b0, gap_pend = 1'b0, prev_take = 1'b0, prev_txv = 1'b0;
    logic [2:0] rd_addr = '0;
    int rx_idx = 2;

    // Master + sensor model: drives inputs on the falling edge, so the pair it sees
    // after driving is exactly what the DUT samples on the next rising edge.
    always @(negedge clk) begin
        cyc++;
        tx_ready = no_ready ? 1'b0 : 1'($urandom_range(0, 1));
        if (tx_valid && tx_ready) begin
            txlog.push_back(tx_data);
            if (tx_data == 8'h00) begin t_ptr = cyc; ptr_pend = 1'b1; end
            if (tx_data[0]) begin rd_addr = tx_data[3:1]; rx_idx = 0; end
        end
        rx_valid = rx_ready && (rx_idx < 2) && ($urandom_range(0, 1) == 1);
        rx_data  = (rx_idx == 0) ? sens[rd_addr][15:8] : sens[rd_addr][7:0];
        if (rx_valid && rx_ready) rx_idx++;
        if (take_bus && !prev_take) begin
            if (gap_pend) begin gap_meas = cyc - t_stb; gap_pend = 1'b0; end
            if (ptr_pend) begin conv_meas = cyc - t_ptr; ptr_pend = 1'b0; end
        end
        if (sample_stb) begin t_stb = cyc; gap_pend = 1'b1; end
        if (tx_valid && !prev_txv) t_txv_rise = cyc;
        if (!tx_valid && prev_txv) txv_len = cyc - t_txv_rise;
        prev_take = take_bus;
        prev_txv  = tx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pop_tx();
        if (txlog.size() == 0) return 8'hxx;
        return txlog.pop_front();
    endfunction

    // Wait for the next update pulse, check it against the model, then step one cycle.
    task automatic txn(input bit err);
        int w = 0;
        logic [7:0] a;
        while (sample_stb !== 1'b1 && w < 4000) begin @(negedge clk); w++; end
        chk("stb_seen", {31'd0, sample_stb}, 32'd1);
        if (sample_stb === 1'b1) begin
            chk("sample_ch", {29'd0, sample_ch}, m_ch);
            if (!err) begin
                a = {4'b1001, m_addr[m_ch], 1'b0};
                chk("tx_ptr_addr", {24'd0, pop_tx()}, {24'd0, a});
                chk("tx_ptr_byte", {24'd0, pop_tx()}, 32'd0);
                chk("tx_rd_addr",  {24'd0, pop_tx()}, {24'd0, a | 8'h01});
                m_temp[m_ch]  = sens[m_addr[m_ch]];
                m_valid[m_ch] = 1'b1;
                m_err[m_ch]   = 1'b0;
                m_alert[m_ch] = ($signed(m_temp[m_ch]) >= $signed(alert_thr));
            end else begin
                m_err[m_ch] = 1'b1;
            end
            chk("temp_bus",   temp_bus, {m_temp[1], m_temp[0]});
            chk("temp_valid", {30'd0, temp_valid}, {30'd0, m_valid});
            chk("temp_err",   {30'd0, temp_err},   {30'd0, m_err});
            chk("alert",      {30'd0, alert},      {30'd0, m_alert});
            m_ch = (m_ch + 1) % N_CH;
        end
        txlog.delete();
        @(negedge clk);
    endtask

    task automatic set_addrs(input logic [2:0] a0, input logic [2:0] a1);
        m_addr[0] = a0;
        m_addr[1] = a1;
        ch_addr   = {a1, a0};
    endtask

    initial begin
        int w;
        rst_n = 1'b0; enable = 1'b0; ack_lost = 1'b0;
        conv_wait = 4; alert_thr = 16'h1800;
        for (int i = 0; i < 8; i++) sens[i] = 16'h0000;
        for (int i = 0; i < N_CH; i++) m_temp[i] = 16'h0000;
        sens[0] = 16'h1900;
        sens[5] = 16'hE700;
        set_addrs(3'd0, 3'd5);

        repeat (3) @(negedge clk);
        chk("rst_ctl",   {24'd0, take_bus, tx_valid, rx_ready, sample_stb, busy, tx_data[2:0]}, 32'd0);
        chk("rst_temp",  temp_bus, 32'd0);
        chk("rst_flags", {23'd0, temp_valid, temp_err, alert, sample_ch}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_disabled", {31'd0, busy}, 32'd0);

        // First round: fixed addresses/readings, then long conversion on ch1.
        enable = 1'b1;
        txn(1'b0);
        conv_wait = 1000;
        txn(1'b0);
        chk("tp_temp_bus",   temp_bus, 32'hE700_1900);
        chk("tp_valid",      {30'd0, temp_valid}, 32'd3);
        chk("tp_alert",      {30'd0, alert}, 32'd1);
        chk("conv_to_rdtake", conv_meas, 32'd1001);
        chk("commit_to_ptr", gap_meas, 32'(GAP_CYC));

        // Randomised rounds: addresses, readings, thresholds and conversion times.
        for (int r = 0; r < 4; r++) begin
            set_addrs(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            sens[m_addr[0]] = 16'($urandom);
            sens[m_addr[1]] = 16'($urandom);
            alert_thr = (r == 0) ? sens[m_addr[0]] : 16'($urandom);
            conv_wait = $urandom_range(0, 20);
            txn(1'b0);
            txn(1'b0);
        end

        // Establish ch1 = 0x1234, then lose ACK during ch1's pointer address.
        set_addrs(3'd2, 3'd6);
        sens[2] = 16'($urandom);
        sens[6] = 16'h1234;
        txn(1'b0);
        txn(1'b0);
        txn(1'b0);
        w = 0;
        while (tx_valid !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        chk("busy_running", {31'd0, busy}, 32'd1);
        ack_lost = 1'b1;
        @(negedge clk);
        ack_lost = 1'b0;
        chk("ack_lost_take", {31'd0, take_bus}, 32'd0);
        chk("ack_lost_txv",  {31'd0, tx_valid}, 32'd0);
        txn(1'b1);
        chk("ack_lost_keep", {16'd0, temp_bus[31:16]}, 32'h1234);
        sens[6] = 16'h0420;
        txn(1'b0);
        txn(1'b0);
        chk("err_cleared", {31'd0, temp_err[1]}, 32'd0);

        // Master never accepts: ch0 times out, ch1 still polls normally.
        no_ready = 1'b1;
        txn(1'b1);
        chk("timeout_len", txv_len, 32'(TIMEOUT_CYC));
        no_ready = 1'b0;
        txn(1'b0);

        // Drop enable during CONV: the read finishes, then the poller parks.
        conv_wait = 200;
        w = 0;
        while (take_bus !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
        while (take_bus !== 1'b0 && w < 4000) begin @(negedge clk); w++; end
        enable = 1'b0;
        txn(1'b0);
        repeat (GAP_CYC + 10) @(negedge clk);
        chk("parked_busy", {31'd0, busy}, 32'd0);
        chk("parked_take", {31'd0, take_bus}, 32'd0);

        // Reset in the middle of the MSB read.
        enable = 1'b1;
        w = 0;
        while (rx_ready !== 1'b1 && w < 3000) begin @(negedge clk); w++; end
        chk("in_rd_msb", {31'd0, rx_ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctl",   {24'd0, take_bus, tx_valid, rx_ready, sample_stb, busy, tx_data[2:0]}, 32'd0);
        chk("midrst_temp",  temp_bus, 32'd0);
        chk("midrst_flags", {23'd0, temp_valid, temp_err, alert, sample_ch}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
